// File: rtl/vx_warp_barrier_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vx_warp_barrier_ctrl
// Brief   : Local warp barrier sequencer. Stalls arriving warps per barrier id
//           and releases them together once the expected count has arrived.
// Revision: 1.0 - initial release
// ============================================================================
module vx_warp_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NW_WIDTH-1:0]     req_wid,
  input  logic [NB_WIDTH-1:0]     req_id,
  input  logic [NW_WIDTH-1:0]     req_size_m1,
  input  logic                    req_is_noop,
  output logic [NUM_WARPS-1:0]    stalled_mask,
  output logic [NUM_BARRIERS-1:0] active_mask,
  output logic                    rel_valid,
  output logic [NB_WIDTH-1:0]     rel_id,
  output logic [NUM_WARPS-1:0]    rel_wmask,
  output logic                    err_dup
);

  logic [NUM_WARPS-1:0]    r_wait_mask [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]     r_count     [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]     r_size_m1   [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] r_active;

  logic                    r_ready;
  logic                    r_rel_valid;
  logic [NB_WIDTH-1:0]     r_rel_id;
  logic [NUM_WARPS-1:0]    r_rel_wmask;
  logic                    r_err_dup;

  logic [NUM_WARPS-1:0]    w_stalled;
  logic [NUM_WARPS-1:0]    w_wid_onehot;
  logic                    w_accept;

  always_comb begin
    w_stalled = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      w_stalled = w_stalled | r_wait_mask[b];
    end
  end

  assign w_wid_onehot = NUM_WARPS'(1) << req_wid;
  assign w_accept     = req_valid && r_ready && !req_is_noop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ready     <= 1'b0;
      r_rel_valid <= 1'b0;
      r_rel_id    <= '0;
      r_rel_wmask <= '0;
      r_err_dup   <= 1'b0;
      r_active    <= '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_wait_mask[b] <= '0;
        r_count[b]     <= '0;
        r_size_m1[b]   <= '0;
      end
    end else begin
      r_ready     <= 1'b1;
      r_rel_valid <= 1'b0;
      r_rel_id    <= '0;
      r_rel_wmask <= '0;
      r_err_dup   <= 1'b0;
      if (w_accept) begin
        if (w_stalled[req_wid]) begin
          // A warp can only wait on one barrier at a time; flag and ignore.
          r_err_dup <= 1'b1;
        end else if (!r_active[req_id]) begin
          r_size_m1[req_id] <= req_size_m1;
          if (req_size_m1 == '0) begin
            r_rel_valid <= 1'b1;
            r_rel_id    <= req_id;
            r_rel_wmask <= w_wid_onehot;
          end else begin
            r_active[req_id]    <= 1'b1;
            r_wait_mask[req_id] <= w_wid_onehot;
            r_count[req_id]     <= NW_WIDTH'(1);
          end
        end else if (r_count[req_id] == r_size_m1[req_id]) begin
          r_rel_valid         <= 1'b1;
          r_rel_id            <= req_id;
          r_rel_wmask         <= r_wait_mask[req_id] | w_wid_onehot;
          r_active[req_id]    <= 1'b0;
          r_wait_mask[req_id] <= '0;
          r_count[req_id]     <= '0;
        end else begin
          r_wait_mask[req_id] <= r_wait_mask[req_id] | w_wid_onehot;
          r_count[req_id]     <= r_count[req_id] + NW_WIDTH'(1);
        end
      end
    end
  end

  assign req_ready    = r_ready;
  assign stalled_mask = w_stalled;
  assign active_mask  = r_active;
  assign rel_valid    = r_rel_valid;
  assign rel_id       = r_rel_id;
  assign rel_wmask    = r_rel_wmask;
  assign err_dup      = r_err_dup;

endmodule
`default_nettype wire

// File: doc/vx_warp_barrier_ctrl.md
Name: vx_warp_barrier_ctrl

Overview:
- Per-core controller that sequences local warp barriers, as described by the barrier request record (valid, id, is_global, size_m1, is_noop).
- Accepts one barrier arrival per cycle from the warp-control unit.
- Holds arriving warps stalled until the expected number of warps reaches the same barrier id, then releases them together with a single-cycle release pulse.
- Sits between the warp-control execute stage and the scheduler's warp stall mask. Global (cross-core) barriers are out of scope for this block.

Parameters:
- NUM_WARPS, 4, number of warps per core; NW_WIDTH = max(1, clog2(NUM_WARPS))
- NUM_BARRIERS, 4, number of local barrier ids; NB_WIDTH = max(1, clog2(NUM_BARRIERS))

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  1  barrier arrival valid
- req_ready  out  1  controller can accept an arrival
- req_wid  in  NW_WIDTH  arriving warp id
- req_id  in  NB_WIDTH  barrier id
- req_size_m1  in  NW_WIDTH  participating warps minus one
- req_is_noop  in  1  arrival carries no barrier effect
- stalled_mask  out  NUM_WARPS  warps currently blocked on any barrier
- active_mask  out  NUM_BARRIERS  barriers with at least one waiting warp
- rel_valid  out  1  one-cycle release pulse
- rel_id  out  NB_WIDTH  released barrier id
- rel_wmask  out  NUM_WARPS  warps released, including the final arriver
- err_dup  out  1  one-cycle pulse: arrival from a warp already stalled

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n).
- Per-barrier state:
  - wait mask [NUM_WARPS]
  - arrival count [NW_WIDTH]
  - latched size_m1 [NW_WIDTH]
  - active bit
- Reset (reset_n=0 at a clk edge) clears all state. All outputs are 0, including req_ready. req_ready goes to 1 on the first edge after reset_n=1 and stays 1. A reset in the middle of an operation drops all waiting warps; no release pulse is generated.
- An arrival is accepted when req_valid && req_ready. All effects are registered and visible at T+1.
- Accepted arrival with req_is_noop=1: no state change, no pulse.
- Duplicate arrival: stalled_mask[req_wid]=1 at T. Result at T+1: err_dup=1, state unchanged. The warp is not stalled twice.
- First arrival on an inactive barrier:
  - latch req_size_m1.
  - If size_m1==0, release immediately: rel_valid=1, rel_wmask=onehot(wid), no stall.
  - Otherwise set active, set the wait-mask bit, set count=1, set the stalled_mask bit.
- Later arrival on an active barrier:
  - The latched size_m1 is authoritative; req_size_m1 is ignored.
  - If count == latched size_m1: release. rel_valid=1, rel_id=id, rel_wmask = wait mask | onehot(wid). Clear the wait mask, count and active bit. The released warps' stalled_mask bits read 0 in the same cycle T+1 that rel_valid=1.
  - Otherwise set the wait-mask bit and count+1.
- Count arithmetic is NW_WIDTH wide. It cannot wrap, because the release fires at count==size_m1 ≤ NUM_WARPS-1.
- stalled_mask = OR of all wait masks. active_mask[b] = active bit of barrier b.
- rel_valid, rel_id, rel_wmask and err_dup are pulses. When rel_valid=0, rel_id and rel_wmask hold 0.
- A barrier released at T+1 may take a new first arrival accepted at T+1. Its state is fresh.
- Distinct barriers are independent. Up to NUM_BARRIERS barriers can be active at once, with disjoint wait masks.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req_valid=1 -> req_ready=0, stalled_mask=0, no pulses. After release of reset: req_ready=1 next cycle.
- size_m1=2, barrier 1: warps 0, 2, 3 arrive on consecutive cycles -> stalled_mask goes 0001, 0101. On the 3rd arrival, next cycle: rel_valid=1, rel_id=1, rel_wmask=1101, stalled_mask=0000, active_mask=0000.
- size_m1=0 from warp 3 on barrier 0 -> next cycle rel_valid=1, rel_wmask=1000. stalled_mask never set.
- Warp 1 arrives on barrier 2 (size_m1=1), then warp 1 again -> err_dup=1 once, count stays 1. Then warp 0 arrives -> rel_wmask=0011.
- Interleave barriers 0 and 3, each with size_m1=1: warps 0→b0, 1→b3, 2→b0, 3→b3 -> releases 0101 for id 0, then 1010 for id 3. An is_noop arrival in between changes nothing.
- Mid-operation reset: warps 0 and 1 waiting on b2 (size_m1=3), then reset_n=0 for 1 cycle -> stalled_mask=0, active_mask=0, no rel_valid. A later full barrier behaves normally.
